// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, word geometry and legal latency bounds.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DATA_W   = 32;
    localparam int WORD_OFS = 2;
    localparam int LAT_MIN  = 1;
    localparam int LAT_MAX  = 15;
    localparam int CNT_W    = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, combinational read.
// With INIT_ZERO the contents start at zero; nothing ever clears them afterwards.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    if (INIT_ZERO != 0) begin : g_zero_init
        logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};

        always_ff @(posedge clk_i) begin
            if (we_i) begin
                mem[waddr_i] <= wdata_i;
            end
        end

        assign rdata_o = mem[raddr_i];
    end else begin : g_no_init
        logic [DATA_W-1:0] mem [0:DEPTH-1];

        always_ff @(posedge clk_i) begin
            if (we_i) begin
                mem[waddr_i] <= wdata_i;
            end
        end

        assign rdata_o = mem[raddr_i];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one word request, acks LATENCY cycles after acceptance.
// Latency LATENCY (1..15), ack spacing >= LATENCY+1; busy_o stalls the CPU while outstanding.
// Optional MEM_ALIGN_CHECK_EN adds err_o and suppresses misaligned accesses.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int LATENCY   = 3,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ack_o,
    output logic [31:0]       rdata_o,
    output logic              busy_o
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              err_o
`endif
);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("data_mem_responder: LATENCY out of range");
    end

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_we;
    logic [ADDR_W+1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;

    logic               cur_we;
    logic [ADDR_W+1:0]  cur_addr;
    logic               cur_mis;
    logic               lat_mis;
    logic               to_resp;
    logic               mem_we;
    logic [DATA_W-1:0]  mem_rdata;
    logic               unused_addr;

    assign unused_addr = ^addr_i[31:ADDR_W+2];

    // With LATENCY=1 the RESP entry coincides with acceptance, so the live inputs are used.
    assign cur_we   = (state == ST_IDLE) ? we_i : lat_we;
    assign cur_addr = (state == ST_IDLE) ? addr_i[ADDR_W+1:0] : lat_addr;
    assign cur_mis  = ALIGN_CHK && (cur_addr[WORD_OFS-1:0] != '0);
    assign lat_mis  = ALIGN_CHK && (lat_addr[WORD_OFS-1:0] != '0);

    assign to_resp = ((state == ST_IDLE) && req_i && (LATENCY == 1)) ||
                     ((state == ST_WAIT) && (cnt == '0));

    // Write lands on the edge that closes RESP; a reset on that edge abandons it.
    assign mem_we = (state == ST_RESP) && lat_we && !lat_mis && !rst_i;

    dmem_array #(
        .ADDR_W    (ADDR_W),
        .INIT_ZERO (INIT_ZERO)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (lat_addr[ADDR_W+1:WORD_OFS]),
        .wdata_i (lat_wdata),
        .raddr_i (cur_addr[ADDR_W+1:WORD_OFS]),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ack_o     <= 1'b0;
            rdata_o   <= '0;
            busy_o    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            err_o     <= 1'b0;
`endif
        end else begin
            ack_o <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            err_o <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        lat_we    <= we_i;
                        lat_addr  <= addr_i[ADDR_W+1:0];
                        lat_wdata <= wdata_i;
                        busy_o    <= 1'b1;
                        if (LATENCY == 1) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_W'(LATENCY - 2);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase

            if (to_resp) begin
                ack_o <= 1'b1;
                if (!cur_we && !cur_mis) begin
                    rdata_o <= mem_rdata;
                end
`ifdef MEM_ALIGN_CHECK_EN
                err_o <= cur_mis;
`endif
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a transaction-level memory model.
module tb_data_mem_responder;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 3;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        busy_o;
`ifdef MEM_ALIGN_CHECK_EN
    logic        err_o;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          ack_cyc  = 0;
    logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
    logic [31:0] rd_last;

    data_mem_responder #(
        .ADDR_W    (ADDR_W),
        .LATENCY   (LATENCY),
        .INIT_ZERO (1)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .ack_o   (ack_o),
        .rdata_o (rdata_o),
        .busy_o  (busy_o)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .err_o   (err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of the following idle cycle.
    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit scramble, input bit keep_req, input string tag);
        int          idx;
        bit          mis;
        logic [31:0] exp_rd;
        idx = int'(a[ADDR_W+1:2]);
        mis = ALIGN && (a[1:0] != 2'b00);
        req_i   = 1'b1;
        we_i    = w;
        addr_i  = a;
        wdata_i = d;
        #1;
        check_eq({tag, " busy_at_accept"}, 32'(busy_o), 32'd0);
        @(posedge clk_i); #1;
        for (int k = 0; k < LATENCY; k++) begin
            check_eq({tag, " busy"}, 32'(busy_o), 32'd1);
            check_eq({tag, " ack"}, 32'(ack_o), 32'(k == LATENCY-1));
            if (k == LATENCY-1) begin
                exp_rd = (!w && !mis) ? ref_mem[idx] : rd_last;
                check_eq({tag, " rdata"}, rdata_o, exp_rd);
`ifdef MEM_ALIGN_CHECK_EN
                check_eq({tag, " err"}, 32'(err_o), 32'(mis));
`endif
                ack_cyc = cyc;
                rd_last = exp_rd;
                if (w && !mis) ref_mem[idx] = d;
            end
            @(negedge clk_i);
            if (k == LATENCY-1) begin
                req_i = keep_req;
            end else if (scramble) begin
                we_i    = 1'($urandom);
                addr_i  = $urandom;
                wdata_i = $urandom;
            end
            if (k < LATENCY-1) begin
                @(posedge clk_i); #1;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq({tag, " ack_after"}, 32'(ack_o), 32'd0);
        check_eq({tag, " busy_after"}, 32'(busy_o), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
            check_eq("idle ack", 32'(ack_o), 32'd0);
            check_eq("idle busy", 32'(busy_o), 32'd0);
            @(negedge clk_i);
        end
    endtask

    initial begin
        int          prev;
        bit          w;
        bit          keep;
        logic [31:0] a;
        for (int i = 0; i < (1<<ADDR_W); i++) ref_mem[i] = '0;
        rd_last = '0;

        // Reset held with a pending write request
        rst_i   = 1'b1;
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = 32'h10;
        wdata_i = 32'hCAFEF00D;
        repeat (2) begin
            @(posedge clk_i); #1;
            check_eq("rst ack", 32'(ack_o), 32'd0);
            check_eq("rst busy", 32'(busy_o), 32'd0);
            check_eq("rst rdata", rdata_o, 32'd0);
        end
        @(negedge clk_i);
        rst_i = 1'b0;

        // Write then read
        txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, "wr10");
        txn(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, "rd10");
        check_eq("rd10 value", rdata_o, 32'hDEADBEEF);

        // Back-to-back reads with req held high
        for (int i = 0; i < 4; i++)
            txn(1'b1, 32'(i*4), 32'(i+1), 1'b0, 1'b0, "preload");
        txn(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "b2b0");
        check_eq("b2b0 value", rdata_o, 32'd1);
        for (int i = 1; i < 4; i++) begin
            prev = ack_cyc;
            txn(1'b0, 32'(i*4), 32'h0, 1'b0, (i < 3), "b2b");
            check_eq("b2b value", rdata_o, 32'(i+1));
            check_eq("b2b spacing", 32'(ack_cyc - prev), 32'(LATENCY+1));
        end

        // Reset in the WAIT cycle abandons the write
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = 32'h20;
        wdata_i = 32'h55AA55AA;
        @(posedge clk_i); #1;
        check_eq("mid busy", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        req_i = 1'b0;
        @(posedge clk_i); #1;
        check_eq("mid rst busy", 32'(busy_o), 32'd0);
        check_eq("mid rst ack", 32'(ack_o), 32'd0);
        check_eq("mid rst rdata", rdata_o, 32'd0);
        rd_last = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(LATENCY + 1);
        txn(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, "mid rd20");
        check_eq("mid rd20 value", rdata_o, 32'd0);

        // Address wrap plus inputs scrambled while busy
        txn(1'b1, 32'h1000, 32'h12345678, 1'b1, 1'b0, "wrap wr");
        txn(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "wrap rd");
        check_eq("wrap value", rdata_o, 32'h12345678);

`ifdef MEM_ALIGN_CHECK_EN
        txn(1'b0, 32'h3, 32'h0, 1'b0, 1'b0, "mis rd");
        check_eq("mis rd keeps rdata", rdata_o, 32'h12345678);
        txn(1'b1, 32'h11, 32'hBAD0BAD0, 1'b0, 1'b0, "mis wr");
        txn(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, "mis chk");
        check_eq("mis wr no store", rdata_o, 32'hDEADBEEF);
`endif

        // Random traffic over a small word window with aliased upper bits
        for (int i = 0; i < 40; i++) begin
            w    = 1'($urandom);
            keep = ($urandom_range(0, 2) == 0);
            a    = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
            txn(w, a, $urandom, 1'($urandom), keep, "rand");
            if (!keep) idle($urandom_range(0, 2));
        end
        // The last random txn may leave req high; finish with a read that drops it.
        txn(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "final");
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
